// File: rtl/attn_spike_lif_drain_pkg.sv
// attn_spike_lif_drain_pkg: shared word geometry, drain FSM encoding and the single LIF step
package attn_spike_lif_drain_pkg;
    localparam int TIME_STEPS = 4;
    localparam int PSUM_W = 12;
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;
    // Returns {spike, next membrane}; the add is one bit wider so V + X cannot wrap before the halving
    function automatic logic [PSUM_W:0] lif_step(input logic [PSUM_W-1:0] v, input logic [PSUM_W-1:0] x,
                                                 input logic [PSUM_W-1:0] v_th);
        logic [PSUM_W-1:0] h;
        h = PSUM_W'(({1'b0, v} + {1'b0, x}) >> 1);
        return (h >= v_th) ? {1'b1, {PSUM_W{1'b0}}} : {1'b0, h};
    endfunction
endpackage

// File: rtl/attn_spike_lif_core.sv
// attn_spike_lif_core: combinational four-step LIF chain, membrane starts at 0 for each word
//   psum   : TIME_STEPS partial sums, T0 in the LSBs
//   spikes : one spike per time step, bit t = Tt
module attn_spike_lif_core
    import attn_spike_lif_drain_pkg::*;
#(
    parameter logic [PSUM_W-1:0] V_TH = 8
) (
    input  logic [TIME_STEPS*PSUM_W-1:0] psum,
    output logic [TIME_STEPS-1:0]        spikes
);
    logic [PSUM_W:0] r [TIME_STEPS];
    for (genvar t = 0; t < TIME_STEPS; t++) begin : g_step
        if (t == 0) begin : g_first
            assign r[t] = lif_step('0, psum[t*PSUM_W +: PSUM_W], V_TH);
        end else begin : g_next
            assign r[t] = lif_step(r[t-1][PSUM_W-1:0], psum[t*PSUM_W +: PSUM_W], V_TH);
        end
        assign spikes[t] = r[t][PSUM_W];
    end
endmodule

// File: rtl/attn_spike_lif_drain.sv
// attn_spike_lif_drain: drains one accumulated line through LIF neurons to a valid/ready spike stream
//   s_clk, s_rst (sync, active-high)
//   i_Drain_start        : line complete, begin draining (ignored unless idle)
//   o_finalMacData_valid : buffer read strobe, data returns on i_finalMacData_out next cycle
//   o_Spikes_valid/i_Spikes_ready/o_Spikes/o_Spikes_idx : show-ahead output stream
//   o_Finish_once        : pulse after the last word of the line is accepted
//   o_busy               : high from accepted start through o_Finish_once
module attn_spike_lif_drain
    import attn_spike_lif_drain_pkg::*;
#(
    parameter int                LINE_LEN = 64,
    parameter logic [PSUM_W-1:0] V_TH     = 8
) (
    input  logic                          s_clk,
    input  logic                          s_rst,
    input  logic                          i_Drain_start,
    output logic                          o_finalMacData_valid,
    input  logic [TIME_STEPS*PSUM_W-1:0]  i_finalMacData_out,
    output logic                          o_Spikes_valid,
    input  logic                          i_Spikes_ready,
    output logic [TIME_STEPS-1:0]         o_Spikes,
    output logic [$clog2(LINE_LEN)-1:0]   o_Spikes_idx,
    output logic                          o_Finish_once,
    output logic                          o_busy
);
    localparam int IDX_W = $clog2(LINE_LEN);
    state_t                  state;
    logic [IDX_W-1:0]        rd_idx, fl_idx;
    logic                    in_flight;
    logic [TIME_STEPS-1:0]   mem_s [2];
    logic [IDX_W-1:0]        mem_i [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count, occ;
    logic [TIME_STEPS-1:0]   lif_spikes;
    logic                    pop, rd_en, last_rd, last_pop;
    attn_spike_lif_core #(.V_TH(V_TH)) u_core (.psum(i_finalMacData_out), .spikes(lif_spikes));
    assign o_Spikes_valid = count != 2'd0;
    assign o_Spikes = mem_s[rd_ptr];
    assign o_Spikes_idx = mem_i[rd_ptr];
    assign pop = o_Spikes_valid && i_Spikes_ready;
    // Occupancy after this edge without a new read; the word leaving this cycle frees its slot now,
    // which is what sustains one word per cycle with two slots and a one-cycle read latency
    assign occ = count + {1'b0, in_flight} - {1'b0, pop};
    assign rd_en = !s_rst && state == DRAIN && occ < 2'd2;
    assign o_finalMacData_valid = rd_en;
    assign last_rd = rd_idx == IDX_W'(LINE_LEN - 1);
    assign last_pop = pop && o_Spikes_idx == IDX_W'(LINE_LEN - 1);
    assign o_busy = state != IDLE || o_Finish_once;
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state <= IDLE;
            rd_idx <= '0;
            fl_idx <= '0;
            in_flight <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= '0;
            o_Finish_once <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_s[i] <= '0;
                mem_i[i] <= '0;
            end
        end else begin
            in_flight <= rd_en;
            fl_idx <= rd_idx;
            if (rd_en) rd_idx <= last_rd ? '0 : rd_idx + 1'b1;
            if (in_flight) begin
                mem_s[wr_ptr] <= lif_spikes;
                mem_i[wr_ptr] <= fl_idx;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_flight} - {1'b0, pop};
            o_Finish_once <= state == FLUSH && last_pop;
            case (state)
                IDLE:    if (i_Drain_start) state <= DRAIN;
                DRAIN:   if (rd_en && last_rd) state <= FLUSH;
                FLUSH:   if (last_pop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_attn_spike_lif_drain.sv
// tb_attn_spike_lif_drain: directed checks of reset, full drain, backpressure and mid-drain reset
module tb_attn_spike_lif_drain;
    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        i_Drain_start = 1'b0;
    logic        o_finalMacData_valid;
    logic [47:0] i_finalMacData_out = '0;
    logic        o_Spikes_valid;
    logic        i_Spikes_ready = 1'b0;
    logic [3:0]  o_Spikes;
    logic [5:0]  o_Spikes_idx;
    logic        o_Finish_once;
    logic        o_busy;
    int          total = 0;
    int          bad = 0;
    int          rd_n = 0;
    logic        pend;
    logic [47:0] wrd [8];
    logic [3:0]  exp_s [8];

    attn_spike_lif_drain dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_Drain_start(i_Drain_start),
        .o_finalMacData_valid(o_finalMacData_valid), .i_finalMacData_out(i_finalMacData_out),
        .o_Spikes_valid(o_Spikes_valid), .i_Spikes_ready(i_Spikes_ready), .o_Spikes(o_Spikes),
        .o_Spikes_idx(o_Spikes_idx), .o_Finish_once(o_Finish_once), .o_busy(o_busy)
    );

    always #5 s_clk = ~s_clk;

    // Line-buffer model: a strobe seen in a cycle returns the next pattern word in the following cycle
    initial begin
        forever begin
            @(negedge s_clk);
            pend = o_finalMacData_valid;
            @(posedge s_clk);
            #1;
            if (pend) begin
                i_finalMacData_out = wrd[rd_n % 8];
                rd_n++;
            end
        end
    end

    task automatic test_reset;
        s_rst = 1'b1;
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        total += 6;
        if (o_finalMacData_valid !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", o_finalMacData_valid); end
        if (o_Spikes_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_Spikes_valid); end
        if (o_Spikes !== 4'b0) begin bad++; $display("FAIL reset_spikes got=%b want=0000", o_Spikes); end
        if (o_Spikes_idx !== 6'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", o_Spikes_idx); end
        if (o_Finish_once !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", o_Finish_once); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        @(posedge s_clk);
        #1;
        s_rst = 1'b0;
    endtask

    task automatic test_full_drain;
        int strobes = 0;
        int words = 0;
        int fins = 0;
        int fin_cyc = -1;
        rd_n = 0;
        for (int c = 0; c < 90; c++) begin
            @(posedge s_clk);
            #1;
            i_Drain_start = (c == 0 || c == 20);
            i_Spikes_ready = 1'b1;
            @(negedge s_clk);
            if (c == 0) begin total++; if (o_finalMacData_valid !== 1'b0) begin bad++; $display("FAIL strobe_at_start got=%b want=0", o_finalMacData_valid); end end
            if (c == 1) begin total++; if (o_finalMacData_valid !== 1'b1) begin bad++; $display("FAIL first_strobe got=%b want=1", o_finalMacData_valid); end end
            if (c == 2) begin total++; if (o_Spikes_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b want=0", o_Spikes_valid); end end
            if (c == 3) begin total++; if (o_Spikes_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", o_Spikes_valid); end end
            if (c == 67) begin total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL busy_at_finish got=%b want=1", o_busy); end end
            if (c == 68) begin total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL busy_after_finish got=%b want=0", o_busy); end end
            if (o_finalMacData_valid === 1'b1) strobes++;
            if (o_Finish_once === 1'b1) begin fins++; fin_cyc = c; end
            if (o_Spikes_valid === 1'b1) begin
                total += 2;
                if (o_Spikes_idx !== 6'(words)) begin bad++; $display("FAIL drain_idx got=%0d want=%0d", o_Spikes_idx, words); end
                if (o_Spikes !== exp_s[words % 8]) begin bad++; $display("FAIL drain_spikes idx=%0d got=%b want=%b", words, o_Spikes, exp_s[words % 8]); end
                words++;
            end
        end
        i_Drain_start = 1'b0;
        total += 4;
        if (strobes != 64) begin bad++; $display("FAIL drain_strobes got=%0d want=64", strobes); end
        if (words != 64) begin bad++; $display("FAIL drain_words got=%0d want=64", words); end
        if (fins != 1) begin bad++; $display("FAIL drain_finish_count got=%0d want=1", fins); end
        if (fin_cyc != 67) begin bad++; $display("FAIL drain_finish_cycle got=%0d want=67", fin_cyc); end
    endtask

    task automatic test_backpressure;
        int strobes = 0;
        int words = 0;
        int c = 0;
        bit done = 0;
        bit hold = 0;
        logic [3:0] h_s;
        logic [5:0] h_i;
        rd_n = 0;
        while (!done && c < 2000) begin
            @(posedge s_clk);
            #1;
            i_Drain_start = (c == 0);
            i_Spikes_ready = 1'($urandom_range(0, 1));
            @(negedge s_clk);
            if (hold) begin
                total++;
                if (o_Spikes_valid !== 1'b1 || o_Spikes !== h_s || o_Spikes_idx !== h_i) begin
                    bad++; $display("FAIL bp_stable got=%b/%b/%0d want=1/%b/%0d", o_Spikes_valid, o_Spikes, o_Spikes_idx, h_s, h_i);
                end
            end
            if (o_finalMacData_valid === 1'b1) strobes++;
            if (o_Spikes_valid === 1'b1 && i_Spikes_ready) begin
                total += 2;
                if (o_Spikes_idx !== 6'(words)) begin bad++; $display("FAIL bp_idx got=%0d want=%0d", o_Spikes_idx, words); end
                if (o_Spikes !== exp_s[words % 8]) begin bad++; $display("FAIL bp_spikes idx=%0d got=%b want=%b", words, o_Spikes, exp_s[words % 8]); end
                words++;
            end
            total++;
            if (strobes - words > 2) begin bad++; $display("FAIL bp_outstanding got=%0d want<=2", strobes - words); end
            hold = o_Spikes_valid === 1'b1 && !i_Spikes_ready;
            h_s = o_Spikes;
            h_i = o_Spikes_idx;
            if (o_Finish_once === 1'b1) done = 1;
            c++;
        end
        i_Drain_start = 1'b0;
        i_Spikes_ready = 1'b1;
        total += 3;
        if (!done) begin bad++; $display("FAIL bp_timeout got=no_finish want=finish"); end
        if (words != 64) begin bad++; $display("FAIL bp_words got=%0d want=64", words); end
        if (strobes != 64) begin bad++; $display("FAIL bp_strobes got=%0d want=64", strobes); end
        repeat (2) @(posedge s_clk);
    endtask

    task automatic test_reset_mid;
        int c = 0;
        bit hit = 0;
        rd_n = 0;
        while (!hit && c < 200) begin
            @(posedge s_clk);
            #1;
            i_Drain_start = (c == 0);
            i_Spikes_ready = 1'b1;
            @(negedge s_clk);
            if (o_Spikes_valid === 1'b1 && o_Spikes_idx === 6'd30) hit = 1;
            c++;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL mid_reach_word30 got=timeout want=idx30"); end
        @(posedge s_clk);
        #1;
        i_Drain_start = 1'b0;
        s_rst = 1'b1;
        @(negedge s_clk);
        total++;
        if (o_finalMacData_valid !== 1'b0) begin bad++; $display("FAIL mid_strobe_in_reset got=%b want=0", o_finalMacData_valid); end
        @(posedge s_clk);
        #1;
        s_rst = 1'b0;
        @(negedge s_clk);
        total += 5;
        if (o_Spikes_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", o_Spikes_valid); end
        if (o_Spikes !== 4'b0) begin bad++; $display("FAIL mid_spikes got=%b want=0000", o_Spikes); end
        if (o_Spikes_idx !== 6'd0) begin bad++; $display("FAIL mid_idx got=%0d want=0", o_Spikes_idx); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", o_busy); end
        if (o_finalMacData_valid !== 1'b0) begin bad++; $display("FAIL mid_strobe_after got=%b want=0", o_finalMacData_valid); end
        test_full_drain();
    endtask

    initial begin
        wrd[0] = {12'd0, 12'd0, 12'd0, 12'd16};          exp_s[0] = 4'b0001;
        wrd[1] = {12'd6, 12'd6, 12'd6, 12'd6};           exp_s[1] = 4'b0000;
        wrd[2] = {12'd10, 12'd10, 12'd10, 12'd10};       exp_s[2] = 4'b0100;
        wrd[3] = {12'd4095, 12'd4095, 12'd4095, 12'd4095}; exp_s[3] = 4'b1111;
        wrd[4] = {12'd0, 12'd0, 12'd0, 12'd15};          exp_s[4] = 4'b0000;
        wrd[5] = {12'd15, 12'd15, 12'd15, 12'd15};       exp_s[5] = 4'b1010;
        wrd[6] = {12'd0, 12'd0, 12'd4095, 12'd14};       exp_s[6] = 4'b0010;
        wrd[7] = {12'd17, 12'd0, 12'd0, 12'd0};          exp_s[7] = 4'b1000;
        test_reset();
        test_full_drain();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
